async_reset: RTL and testbench

ASYNC_RESET -- requirements
Module: async_reset

---
 rtl/async_reset_pkg.sv | 23 ++
 rtl/rst_sync_chain.sv | 32 +++
 rtl/async_reset.sv | 71 +++++++
 tb/tb_async_reset.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/async_reset_pkg.sv
// Shared constants and helpers for the reset synchronizer.
`timescale 1ns / 10ps

package async_reset_pkg;

  // Legal synchronizer depths (flops on the release path).
  localparam int unsigned STAGES_MIN  = 2;
  localparam int unsigned STAGES_MAX  = 8;

  // Upper bound on extra hold cycles. The lower bound is 0, which an unsigned parameter always meets.
  localparam int unsigned STRETCH_MAX = 255;

  // Stretch counter width: ceil(log2(stretch+1)), never less than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned stretch);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < (stretch + 32'd1)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Shift-register synchronizer for reset release: asynchronous set, deasserted level shifted in.
`timescale 1ns / 10ps

module rst_sync_chain
  import async_reset_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_sync
);

  if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("rst_sync_chain: STAGES=%0d out of range", STAGES);
  end

  // Power-up value equals the asserted state so reset holds from time zero.
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain = '1;

  // Async set on i_rst_n low; on release a zero walks toward o_sync one flop per edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      chain <= '1;
    end else begin
      chain <= chain << 1;
    end
  end

  assign o_sync = chain[STAGES-1];

endmodule

// File: rtl/async_reset.sv
// Reset bridge: asynchronous assert, synchronous release after STAGES+STRETCH clock edges.
`timescale 1ns / 10ps

module async_reset
  import async_reset_pkg::*;
#(
  parameter int unsigned STAGES  = 2,
  parameter int unsigned STRETCH = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_rst,
  output logic o_rst_n
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("async_reset: STAGES=%0d out of range %0d..%0d", STAGES, STAGES_MIN, STAGES_MAX);
  end

  if (STRETCH > STRETCH_MAX) begin : g_bad_stretch
    $error("async_reset: STRETCH=%0d exceeds %0d", STRETCH, STRETCH_MAX);
  end

  localparam int unsigned   CW       = cnt_width(STRETCH);
  localparam logic [CW-1:0] CNT_INIT = CW'(STRETCH);

  logic          chain_out;
  logic          hold;
  logic [CW-1:0] cnt     = CNT_INIT;
  (* ASYNC_REG = "TRUE" *) logic rst_q   = 1'b1;
  (* ASYNC_REG = "TRUE" *) logic rst_n_q = 1'b0;

  // The output flops form the final synchronizer stage, so the chain supplies STAGES-1
  // flops; this keeps the release at exactly STAGES+STRETCH edges with registered outputs.
  rst_sync_chain #(
    .STAGES (STAGES - 1)
  ) u_chain (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_sync  (chain_out)
  );

  // Saturating down-counter: reloaded by reset, counts only once the chain has released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= CNT_INIT;
    end else if (!chain_out && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Reset stays requested while the chain or the stretch counter still holds it.
  always_comb begin
    hold = chain_out || (cnt != '0);
  end

  // Complementary output flops share one D source so o_rst_n is always ~o_rst.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_q   <= 1'b1;
      rst_n_q <= 1'b0;
    end else begin
      rst_q   <= hold;
      rst_n_q <= ~hold;
    end
  end

  assign o_rst   = rst_q;
  assign o_rst_n = rst_n_q;

endmodule

// File: tb/tb_async_reset.sv
// Scoreboard bench for async_reset: directed timing scenarios plus randomized reset pulses.
`timescale 1ns / 10ps

module tb_async_reset;

  // DUT A: defaults on a gateable clock; DUT B: STAGES=3, STRETCH=4 on a free-running clock.
  logic clk_a   = 1'b1;
  logic clk_b   = 1'b1;
  logic clk_en  = 1'b1;
  logic rst_n_a = 1'b1;
  logic rst_n_b = 1'b1;
  logic rst_a, rst_na, rst_b, rst_nb;

  int checks = 0;
  int errors = 0;

  int    which_q[$];
  logic  exp_q[$];
  string name_q[$];
  int    pushed = 0;
  int    popped = 0;

  initial forever begin
    #5;
    if (clk_en) clk_a = ~clk_a;
  end

  initial forever begin
    #5;
    clk_b = ~clk_b;
  end

  async_reset dut_a (
    .i_clk   (clk_a),
    .i_rst_n (rst_n_a),
    .o_rst   (rst_a),
    .o_rst_n (rst_na)
  );

  async_reset #(
    .STAGES  (3),
    .STRETCH (4)
  ) dut_b (
    .i_clk   (clk_b),
    .i_rst_n (rst_n_b),
    .o_rst   (rst_b),
    .o_rst_n (rst_nb)
  );

  task automatic at(input realtime t);
    if (t > $realtime) #(t - $realtime);
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 0) rst_n_a = v;
    else            rst_n_b = v;
  endtask

  function automatic logic cur_rst_n(input int which);
    return (which == 0) ? rst_n_a : rst_n_b;
  endfunction

  task automatic wait_edge(input int which);
    if (which == 0) @(posedge clk_a);
    else            @(posedge clk_b);
  endtask

  // Issue an expectation: the monitor samples the DUT in this same time step.
  task automatic expect_now(input int which, input logic exp_rst, input string name);
    which_q.push_back(which);
    exp_q.push_back(exp_rst);
    name_q.push_back(name);
    pushed++;
    #0.01;
  endtask

  // Monitor: pops each expectation and compares both outputs of the addressed DUT.
  initial forever begin
    int    w;
    logic  e;
    string n;
    logic  act, act_n;
    wait (pushed != popped);
    while (which_q.size() != 0) begin
      w = which_q.pop_front();
      e = exp_q.pop_front();
      n = name_q.pop_front();
      popped++;
      act   = (w == 0) ? rst_a  : rst_b;
      act_n = (w == 0) ? rst_na : rst_nb;
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s dut%0d t=%0t: o_rst=%b required %b", n, w, $realtime, act, e);
      end
      checks++;
      if (act_n !== ~e) begin
        errors++;
        $display("FAIL %s_n dut%0d t=%0t: o_rst_n=%b required %b", n, w, $realtime, act_n, ~e);
      end
    end
  end

  // Default instance: power-up, mid-period assert, release, second pulse, re-assert, short pulse, stopped clock.
  task automatic dir_a();
    at(0.5);    expect_now(0, 1'b1, "powerup");
    at(3.14);   drive(0, 1'b0); #0.01; expect_now(0, 1'b1, "assert_mid");
    at(30.33);  drive(0, 1'b1);
    at(41);     expect_now(0, 1'b1, "rel_edge1");
    at(51);     expect_now(0, 1'b0, "rel_edge2");
    at(70.33);  drive(0, 1'b0); #0.01; expect_now(0, 1'b1, "async_assert");
    at(85.33);  drive(0, 1'b1);
    at(91);     expect_now(0, 1'b1, "pulse2_edge1");
    at(101);    expect_now(0, 1'b0, "pulse2_edge2");
    at(123);    drive(0, 1'b0); #0.01; expect_now(0, 1'b1, "reassert_low");
    at(130.33); drive(0, 1'b1);
    at(141);    expect_now(0, 1'b1, "reassert_e1");
    at(142);    drive(0, 1'b0); #0.01; expect_now(0, 1'b1, "reassert_mid");
    at(144);    drive(0, 1'b1);
    at(151);    expect_now(0, 1'b1, "reassert_restart1");
    at(155);    expect_now(0, 1'b1, "reassert_between");
    at(161);    expect_now(0, 1'b0, "reassert_restart2");
    at(200.33); drive(0, 1'b0); #0.01; expect_now(0, 1'b1, "short_low");
    at(203.33); drive(0, 1'b1);
    at(211);    expect_now(0, 1'b1, "short_edge1");
    at(221);    expect_now(0, 1'b0, "short_edge2");
    at(300.33); drive(0, 1'b0); #0.01; expect_now(0, 1'b1, "stop_assert");
    at(302);    drive(0, 1'b1);
    at(306);    clk_en = 1'b0;
    at(400);    expect_now(0, 1'b1, "clock_stopped");
    at(402);    clk_en = 1'b1;
    at(406);    expect_now(0, 1'b1, "restart_edge1");
    at(416);    expect_now(0, 1'b0, "restart_edge2");
  endtask

  // Stretched instance: 7-edge release and reload of the counter mid-stretch.
  task automatic dir_b();
    at(0.5);    expect_now(1, 1'b1, "b_powerup");
    at(3.14);   drive(1, 1'b0); #0.01; expect_now(1, 1'b1, "b_assert");
    at(30.33);  drive(1, 1'b1);
    at(31);     expect_now(1, 1'b1, "b_released_pin");
    at(41);     expect_now(1, 1'b1, "b_edge1");
    at(71);     expect_now(1, 1'b1, "b_edge4");
    at(91);     expect_now(1, 1'b1, "b_edge6");
    at(101);    expect_now(1, 1'b0, "b_edge7");
    at(113);    drive(1, 1'b0); #0.01; expect_now(1, 1'b1, "b_assert2");
    at(120.33); drive(1, 1'b1);
    at(151);    expect_now(1, 1'b1, "b_counting");
    at(165);    drive(1, 1'b0); #0.01; expect_now(1, 1'b1, "b_reassert_stretch");
    at(167.33); drive(1, 1'b1);
    at(191);    expect_now(1, 1'b1, "b_no_early_release");
    at(221);    expect_now(1, 1'b1, "b_restart_e6");
    at(231);    expect_now(1, 1'b0, "b_restart_e7");
  endtask

  // Reference: o_rst is low only once at least lat consecutive edges have sampled i_rst_n high.
  task automatic run_random(input int which, input int unsigned lat, input int unsigned cycles);
    int unsigned high_edges;
    int unsigned r;
    high_edges = 1000;
    for (int unsigned c = 0; c < cycles; c++) begin
      wait_edge(which);
      if (cur_rst_n(which)) begin
        if (high_edges < 1000) high_edges++;
      end else begin
        high_edges = 0;
      end
      #1;
      expect_now(which, (high_edges < lat) ? 1'b1 : 1'b0, "rand_edge");
      r = $urandom_range(0, 9);
      #1;
      if (cur_rst_n(which)) begin
        if (r == 0) begin
          drive(which, 1'b0);
          high_edges = 0;
          #0.5;
          expect_now(which, 1'b1, "rand_pulse");
          #($urandom_range(1, 3));
          drive(which, 1'b1);
        end else if (r == 1) begin
          drive(which, 1'b0);
          high_edges = 0;
          #0.5;
          expect_now(which, 1'b1, "rand_hold");
        end
      end else if (r < 4) begin
        drive(which, 1'b1);
      end
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      begin
        dir_a();
        at(420);
        run_random(0, 2, 300);
      end
      begin
        dir_b();
        at(250);
        run_random(1, 7, 300);
      end
    join
    #2;
    checks++;
    if (pushed != popped) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", pushed - popped);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
